secure_reg_requester: RTL
=========================

Name: secure_reg_requester

Overview:
- Initiator side of the thread-gated secure register interface.
- Arbitrates round-robin between NUM_THREADS requesting threads and enforces the thread-0-only policy locally.
- Drives one access at a time onto the register port (access_en / wr_en / thread_id / data) and returns a tagged response with an error flag.
- Sits between the per-thread bus masters and a secure register instance.

Parameters:
DATA_WIDTH, 32, register data width
NUM_THREADS, 4, number of requesting threads (2..8)
TID_WIDTH, 2, thread-id width; must satisfy 2**TID_WIDTH >= NUM_THREADS
TIMEOUT, 15, max cycles waiting for reg_ack before error (1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_THREADS  per-thread request; held high until matching gnt
req_we  in  NUM_THREADS  per-thread write (1) / read (0)
req_wdata  in  NUM_THREADS*DATA_WIDTH  per-thread write data; thread i at bits [i*DATA_WIDTH +: DATA_WIDTH]
gnt  out  NUM_THREADS  one-hot, one-cycle acceptance pulse
rsp_valid  out  1  one-cycle response pulse
rsp_tid  out  TID_WIDTH  thread id of the response
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  1 = policy denial or timeout
reg_access_en  out  1  register access strobe
reg_wr_en  out  1  register write enable
reg_thread_id  out  TID_WIDTH  issuing thread id
reg_data_in  out  DATA_WIDTH  write data to register
reg_data_out  in  DATA_WIDTH  read data from register
reg_ack  in  1  register completion; reg_data_out valid in the same cycle

Behaviour:
Reset:
- On rst_n low, async: state IDLE; rr pointer 0; timeout counter 0; all outputs 0.

FSM transitions (IDLE, ISSUE, WAIT, RESP):
- IDLE, any req high: winner = first set req at or after the rr pointer, wrapping modulo NUM_THREADS.
  - gnt[winner] = 1 combinationally in this cycle only.
  - On the clock edge: capture tid, we, wdata; rr pointer <= winner+1, wrapping to 0 after NUM_THREADS-1.
  - Next state ISSUE if tid==0, else RESP with err=1 (denied; no register access is made).
- ISSUE, exactly 1 cycle:
  - reg_access_en=1, reg_wr_en=we, reg_thread_id=tid, reg_data_in=wdata.
  - Counter cleared. Next state WAIT.
- WAIT:
  - reg_* outputs hold their ISSUE values, except reg_access_en=0.
  - On reg_ack: capture reg_data_out if read (0 if write), err=0, go to RESP.
  - Otherwise counter increments. When counter==TIMEOUT-1 and no ack: err=1, rdata=0, go to RESP.
  - reg_ack in the same cycle as the timeout wins (success).
- RESP, 1 cycle:
  - rsp_valid=1; rsp_tid, rsp_rdata, rsp_err registered.
  - Next state IDLE. No new grant in RESP.
- reg_ack outside WAIT is ignored.

Latency:
- Thread-0 access with ack on the first WAIT cycle: gnt at cycle N, ISSUE N+1, WAIT N+2, rsp_valid N+3.
- Denied access: gnt at N, rsp_valid N+1.

Fairness and protocol rules:
- One outstanding access at most. A thread is granted again only after every other requesting thread was considered.
- req dropped before gnt: treated as withdrawn; nothing is captured.
- Reset mid-access aborts it immediately: no response is produced, and reg_access_en drops asynchronously.
- rsp_rdata is 0 whenever rsp_err=1 or the access was a write.

Test Plan:
1. Reset, then thread 0 read; reg_ack on the first WAIT cycle with reg_data_out=0xDEADBEEF -> reg_access_en pulses once with reg_thread_id=0 and reg_wr_en=0; rsp_valid 3 cycles after gnt; rsp_tid=0, rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Thread 2 write of 0x12345678 -> gnt[2] pulse; no reg_access_en ever; rsp_valid next cycle with rsp_tid=2, rsp_err=1, rsp_rdata=0.
3. Threads 0,1,3 request continuously, acks immediate -> grant order 0,1,3,0,1,3; only thread-0 responses have rsp_err=0.
4. Thread 0 read, reg_ack never asserted, TIMEOUT=15 -> rsp_valid with rsp_err=1 and rsp_rdata=0, exactly 15 WAIT cycles after ISSUE; a following request is granted normally.
5. reg_ack coincides with the final timeout cycle, data 0xA5A5A5A5 -> rsp_err=0, rsp_rdata=0xA5A5A5A5.
6. rst_n low during WAIT -> all outputs 0 immediately, no rsp_valid; after release, thread 0 is granted first (rr pointer 0).

Source files
------------

// File: rtl/secure_reg_requester.sv
// Initiator for the thread-gated secure register port: round-robin arbitration
// across requesting threads, local thread-0-only policy, ack timeout, tagged response.
module secure_reg_requester #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_THREADS = 4,
   parameter int TID_WIDTH   = 2,
   parameter int TIMEOUT     = 15
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_THREADS-1:0]            req,
   input  logic [NUM_THREADS-1:0]            req_we,
   input  logic [NUM_THREADS*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_THREADS-1:0]            gnt,
   output logic                              rsp_valid,
   output logic [TID_WIDTH-1:0]              rsp_tid,
   output logic [DATA_WIDTH-1:0]             rsp_rdata,
   output logic                              rsp_err,
   output logic                              reg_access_en,
   output logic                              reg_wr_en,
   output logic [TID_WIDTH-1:0]              reg_thread_id,
   output logic [DATA_WIDTH-1:0]             reg_data_in,
   input  logic [DATA_WIDTH-1:0]             reg_data_out,
   input  logic                              reg_ack
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t               state;
   logic [TID_WIDTH-1:0] rr_ptr;
   logic [TID_WIDTH-1:0] cur_tid;
   logic [7:0]           wait_cnt;
   logic [TID_WIDTH-1:0] win_tid;
   logic                 win_found;

   // Scan from the highest offset down so the first requester at or after rr_ptr wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      win_found = 1'b0;
      win_tid   = '0;
      gnt       = '0;
      for (int k = NUM_THREADS - 1; k >= 0; k--) begin
         if (req[(int'(rr_ptr) + k) % NUM_THREADS]) begin
            win_found = 1'b1;
            win_tid   = TID_WIDTH'((int'(rr_ptr) + k) % NUM_THREADS);
         end
      end
      if (state == IDLE && win_found && rst_n)
         gnt[win_tid] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         cur_tid       <= '0;
         wait_cnt      <= '0;
         rsp_valid     <= 1'b0;
         rsp_tid       <= '0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
         reg_access_en <= 1'b0;
         reg_wr_en     <= 1'b0;
         reg_thread_id <= '0;
         reg_data_in   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         reg_access_en <= 1'b0;
         rsp_valid     <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  cur_tid <= win_tid;
                  rr_ptr  <= (win_tid == TID_WIDTH'(NUM_THREADS - 1)) ? '0
                                                                       : win_tid + TID_WIDTH'(1);
                  if (win_tid == '0) begin
                     reg_access_en <= 1'b1;
                     reg_wr_en     <= req_we[win_tid];
                     reg_thread_id <= win_tid;
                     reg_data_in   <= req_wdata[int'(win_tid)*DATA_WIDTH +: DATA_WIDTH];
                     state         <= ISSUE;
                  end else begin
                     // Policy denial: answered locally, the register never sees it.
                     rsp_valid <= 1'b1;
                     rsp_tid   <= win_tid;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     state     <= RESP;
                  end
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               // An ack in the final timeout cycle still counts as success.
               if (reg_ack) begin
                  rsp_valid <= 1'b1;
                  rsp_tid   <= cur_tid;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= reg_wr_en ? '0 : reg_data_out;
                  state     <= RESP;
               end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                  rsp_valid <= 1'b1;
                  rsp_tid   <= cur_tid;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
